addr_burst_gen: RTL and testbench

Sequential 16-bit address burst generator that sits directly upstream of the address step unit. It accepts a burst command (start address, beat count, direction) and emits one address per beat on a valid/ready stream. Each address is the previous one plus or minus one, modulo 2^16. It tracks remaining beats, marks the last beat, flags wrap-around, and signals completion or abort.

---
 rtl/addr_burst_gen.sv | 143 ++++++++++++++
 tb/tb_addr_burst_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_burst_gen.sv
// addr_burst_gen: sequential address burst generator.
// Accepts a burst command (start address, beat count, direction) and emits
// one address per beat on a valid/ready stream, stepping by +1 or -1 modulo
// 2^AW. Tracks remaining beats, flags the last beat and wrap-around, and
// reports completion or abort with a one-cycle done pulse.
module addr_burst_gen #(
   parameter int AW = 16,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [AW-1:0] start_addr,
   input  logic [LW-1:0] start_len,
   input  logic          start_dir,
   input  logic          abort,
   output logic          addr_valid,
   input  logic          addr_ready,
   output logic [AW-1:0] addr,
   output logic          addr_last,
   output logic          addr_wrap,
   output logic          done,
   output logic          aborted,
   output logic          busy
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state_r, state_s;
   logic [AW-1:0] addr_r, addr_s;
   logic [LW-1:0] rem_r, rem_s;
   logic          dir_r, dir_s;
   logic          wrap_r, wrap_s;
   logic          done_r, done_s;
   logic          aborted_r, aborted_s;
   logic          beat_s;
   logic [AW:0]   step_s;

   // +/-1 step of width AW; bit AW is the carry/borrow out of the MSB,
   // which is set exactly when the step crosses the 0 / all-ones boundary.
   function automatic logic [AW:0] step_addr(input logic [AW-1:0] a, input logic d);
      logic [AW:0] one;
      one = {{AW{1'b0}}, 1'b1};
      if (d == 1'b0) begin
         step_addr = {1'b0, a} + one;
      end else begin
         step_addr = {1'b0, a} - one;
      end
   endfunction

   // Next-state and datapath decisions for the burst FSM.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      rem_s     = rem_r;
      dir_s     = dir_r;
      wrap_s    = wrap_r;
      done_s    = 1'b0;
      aborted_s = 1'b0;
      beat_s    = (state_r == RUN) && addr_ready;
      step_s    = step_addr(addr_r, dir_r);

      case (state_r)
         IDLE: begin
            if (start_valid) begin
               if (start_len != {LW{1'b0}}) begin
                  state_s = RUN;
                  addr_s  = start_addr;
                  rem_s   = start_len;
                  dir_s   = start_dir;
                  wrap_s  = 1'b0;
               end else begin
                  // Empty burst: no beats, just report completion.
                  done_s = 1'b0 | 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               // Abort wins over stepping; a beat in this cycle still counts.
               state_s   = IDLE;
               rem_s     = {LW{1'b0}};
               wrap_s    = 1'b0;
               done_s    = 1'b1;
               aborted_s = 1'b1;
            end else if (beat_s) begin
               if (rem_r == LW'(1)) begin
                  state_s = IDLE;
                  rem_s   = {LW{1'b0}};
                  wrap_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  addr_s = step_s[AW-1:0];
                  rem_s  = rem_r - LW'(1);
                  wrap_s = step_s[AW];
               end
            end else begin
               // Stalled: hold address, last and wrap.
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         addr_r    <= {AW{1'b0}};
         rem_r     <= {LW{1'b0}};
         dir_r     <= 1'b0;
         wrap_r    <= 1'b0;
         done_r    <= 1'b0;
         aborted_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         rem_r     <= rem_s;
         dir_r     <= dir_s;
         wrap_r    <= wrap_s;
         done_r    <= done_s;
         aborted_r <= aborted_s;
      end
   end

   // Outputs decode only from registers, never from inputs.
   assign start_ready = (state_r == IDLE);
   assign busy        = (state_r == RUN);
   assign addr_valid  = (state_r == RUN);
   assign addr        = addr_r;
   assign addr_last   = (state_r == RUN) && (rem_r == LW'(1));
   assign addr_wrap   = wrap_r;
   assign done        = done_r;
   assign aborted     = aborted_r;

endmodule

// File: tb/tb_addr_burst_gen.sv
// tb_addr_burst_gen: directed and randomized checks of addr_burst_gen
// against a queue-based reference model of the expected beat sequence.
module tb_addr_burst_gen;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] start_addr;
   logic [15:0] start_len;
   logic        start_dir;
   logic        abort;
   logic        addr_valid;
   logic        addr_ready;
   logic [15:0] addr;
   logic        addr_last;
   logic        addr_wrap;
   logic        done;
   logic        aborted;
   logic        busy;

   addr_burst_gen #(.AW(16), .LW(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_addr  (start_addr),
      .start_len   (start_len),
      .start_dir   (start_dir),
      .abort       (abort),
      .addr_valid  (addr_valid),
      .addr_ready  (addr_ready),
      .addr        (addr),
      .addr_last   (addr_last),
      .addr_wrap   (addr_wrap),
      .done        (done),
      .aborted     (aborted),
      .busy        (busy)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic        last;
      logic        wrap;
   } beat_t;

   beat_t q[$];          // beats still to be delivered for the current burst
   logic  exp_done;
   logic  exp_aborted;
   int    n_cmp;
   int    n_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expand a command into the full list of beats it must produce.
   task automatic push_burst(input logic [15:0] sa, input logic [15:0] sl, input logic sd);
      beat_t b;
      logic [15:0] a;
      for (int i = 0; i < int'(sl); i++) begin
         a = sd ? (sa - 16'(i)) : (sa + 16'(i));
         b.a    = a;
         b.last = (i == int'(sl) - 1);
         b.wrap = (i != 0) && (a == (sd ? 16'hFFFF : 16'h0000));
         q.push_back(b);
      end
   endtask

   task automatic check_outputs();
      logic run;
      run = (q.size() != 0);
      check_val("start_ready", 32'(start_ready), 32'(!run));
      check_val("busy",        32'(busy),        32'(run));
      check_val("addr_valid",  32'(addr_valid),  32'(run));
      check_val("done",        32'(done),        32'(exp_done));
      check_val("aborted",     32'(aborted),     32'(exp_aborted));
      if (run) begin
         check_val("addr",      32'(addr),      32'(q[0].a));
         check_val("addr_last", 32'(addr_last), 32'(q[0].last));
         check_val("addr_wrap", 32'(addr_wrap), 32'(q[0].wrap));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_start_ready"}, 32'(start_ready), 32'd1);
      check_val({tag, "_busy"},        32'(busy),        32'd0);
      check_val({tag, "_addr_valid"},  32'(addr_valid),  32'd0);
      check_val({tag, "_addr"},        32'(addr),        32'd0);
      check_val({tag, "_addr_last"},   32'(addr_last),   32'd0);
      check_val({tag, "_addr_wrap"},   32'(addr_wrap),   32'd0);
      check_val({tag, "_done"},        32'(done),        32'd0);
      check_val({tag, "_aborted"},     32'(aborted),     32'd0);
   endtask

   // One clock cycle: drive inputs, check outputs, then advance the model
   // to what the next rising edge must produce.
   task automatic cycle(input logic sv, input logic [15:0] sa, input logic [15:0] sl,
                        input logic sd, input logic rdy, input logic ab);
      logic nd;
      logic na;
      @(posedge clk);
      #1;
      start_valid = sv;
      start_addr  = sa;
      start_len   = sl;
      start_dir   = sd;
      addr_ready  = rdy;
      abort       = ab;
      @(negedge clk);
      check_outputs();
      nd = 1'b0;
      na = 1'b0;
      if (q.size() != 0) begin
         if (rdy) begin
            if (q[0].last) nd = 1'b1;
            void'(q.pop_front());
         end
         if (ab) begin
            q.delete();
            nd = 1'b1;
            na = 1'b1;
         end
      end else if (sv) begin
         if (sl == 16'd0) nd = 1'b1;
         else push_burst(sa, sl, sd);
      end
      exp_done    = nd;
      exp_aborted = na;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, rdy, 1'b0);
   endtask

   task automatic pick_addr(output logic [15:0] a);
      case ($urandom_range(0, 5))
         0: a = 16'h0000;
         1: a = 16'h0001;
         2: a = 16'hFFFE;
         3: a = 16'hFFFF;
         default: a = 16'($urandom);
      endcase
   endtask

   // Test sequence: reset, directed scenarios, async reset, random traffic.
   initial begin
      logic [15:0] ra;
      logic [15:0] rl;
      n_cmp       = 0;
      n_err       = 0;
      exp_done    = 1'b0;
      exp_aborted = 1'b0;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      start_addr  = 16'h0000;
      start_len   = 16'h0000;
      start_dir   = 1'b0;
      abort       = 1'b0;
      addr_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Up burst
      cycle(1'b1, 16'h1000, 16'd4, 1'b0, 1'b1, 1'b0);
      idle(6, 1'b1);
      // Down wrap and up wrap
      cycle(1'b1, 16'h0001, 16'd3, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      cycle(1'b1, 16'hFFFE, 16'd3, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);
      // Backpressure 1,0,0,1,1
      cycle(1'b1, 16'h0010, 16'd3, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b1);
      // Abort on third beat, then abort while idle
      cycle(1'b1, 16'h0200, 16'd10, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b1, 1'b1);
      idle(2, 1'b1);
      // Zero length, then back-to-back bursts in the done cycle
      cycle(1'b1, 16'h5555, 16'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 16'd0, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cycle(1'b1, 16'h3000, 16'd2, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cycle(1'b1, 16'h4000, 16'd2, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b1);
      cycle(1'b1, 16'h6000, 16'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'h7000, 16'd1, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // Asynchronous reset in the middle of a burst
      cycle(1'b1, 16'h0800, 16'd10, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      q.delete();
      exp_done    = 1'b0;
      exp_aborted = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("arst_hold");
      rst_n = 1'b1;
      cycle(1'b1, 16'hFFFF, 16'd3, 1'b0, 1'b1, 1'b0);
      idle(5, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         pick_addr(ra);
         rl = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(100, 300))
                                           : 16'($urandom_range(0, 9));
         cycle(1'($urandom_range(0, 2) == 0), ra, rl, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
      end
      idle(4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
